// File: rtl/eth_rx_mac_filter.sv
// Destination-MAC filter for the 64-bit receive AXI-Stream path.
// Decides pass/drop on the first beat of each frame, forwards passing
// frames through a one-entry output register, discards the rest at full
// rate and counts forwarded and discarded frames.
module eth_rx_mac_filter #(
   parameter int DATA_WIDTH  = 64,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                    logic_clk,
   input  logic                    logic_rst_n,

   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                    s_axis_tvalid,
   input  logic                    s_axis_tlast,
   input  logic                    s_axis_tuser,
   output logic                    s_axis_tready,

   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tlast,
   output logic                    m_axis_tuser,
   input  logic                    m_axis_tready,

   input  logic [47:0]             local_mac,
   input  logic                    promisc_en,
   input  logic                    bcast_en,
   input  logic                    mcast_en,

   output logic                    frame_pass,
   output logic                    frame_drop,
   output logic [COUNT_WIDTH-1:0]  pass_count,
   output logic [COUNT_WIDTH-1:0]  drop_count
);

   typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

   state_t      state, state_next;
   logic [47:0] dest;
   logic        runt;
   logic        is_bcast;
   logic        match;
   logic        drop_beat;
   logic        accept;

   // Lane 0 is the first wire byte, which is the most significant byte of
   // the address as written (local_mac[47:40]).
   for (genvar b = 0; b < 6; b++) begin : g_dest
      assign dest[47-8*b -: 8] = s_axis_tdata[8*b +: 8];
   end

   // Match decision, only meaningful while the current beat is a first beat.
   always_comb begin
      runt     = (s_axis_tkeep[5:0] != 6'h3F);
      is_bcast = &dest;
      match    = !runt &&
                 (promisc_en ||
                  (dest == local_mac) ||
                  (bcast_en && is_bcast) ||
                  (mcast_en && dest[40] && !is_bcast));
   end

   // Next state and handshake; dropped beats are always accepted so the
   // discard path never waits on the output side.
   always_comb begin
      state_next = state;
      drop_beat  = 1'b0;
      case (state)
         IDLE:    drop_beat = !match;
         PASS:    drop_beat = 1'b0;
         DROP:    drop_beat = 1'b1;
         default: drop_beat = 1'b1;
      endcase
      s_axis_tready = drop_beat || m_axis_tready || !m_axis_tvalid;
      accept        = s_axis_tvalid && s_axis_tready;
      case (state)
         IDLE:    if (accept && !s_axis_tlast) state_next = match ? PASS : DROP;
         PASS:    if (accept && s_axis_tlast)  state_next = IDLE;
         DROP:    if (accept && s_axis_tlast)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Frame state register.
   always_ff @(posedge logic_clk or negedge logic_rst_n) begin
      if (!logic_rst_n) state <= IDLE;
      else              state <= state_next;
   end

   // One-entry output register; a push and a pop may happen in the same cycle.
   always_ff @(posedge logic_clk or negedge logic_rst_n) begin
      if (!logic_rst_n) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
      end else if (accept && !drop_beat) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= s_axis_tdata;
         m_axis_tkeep  <= s_axis_tkeep;
         m_axis_tlast  <= s_axis_tlast;
         m_axis_tuser  <= s_axis_tuser;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

   // Per-frame pulses and wrapping counters, updated on the accepted first beat.
   always_ff @(posedge logic_clk or negedge logic_rst_n) begin
      if (!logic_rst_n) begin
         frame_pass <= 1'b0;
         frame_drop <= 1'b0;
         pass_count <= '0;
         drop_count <= '0;
      end else begin
         frame_pass <= 1'b0;
         frame_drop <= 1'b0;
         if (accept && state == IDLE) begin
            if (match) begin
               frame_pass <= 1'b1;
               pass_count <= pass_count + COUNT_WIDTH'(1);
            end else begin
               frame_drop <= 1'b1;
               drop_count <= drop_count + COUNT_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: doc/eth_rx_mac_filter.md
# eth_rx_mac_filter

Destination-MAC filter on the 64-bit receive AXI-Stream path, in the `logic_clk` domain. It sits directly downstream of the 10G MAC receive FIFO output (`rx_axis_*`).
- Inspects the first beat of every frame.
- Forwards frames addressed to the local MAC, to broadcast, or (optionally) to multicast, or all frames in promiscuous mode.
- Silently discards every other frame at full rate.
- Keeps pass/drop statistics.

## Interface
- `DATA_WIDTH`, 64: tdata width; fixed, keep is `DATA_WIDTH/8`.
- `COUNT_WIDTH`, 32: width of the statistics counters.

Ports:
- `logic_clk` in 1: single clock for all logic.
- `logic_rst_n` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in 64, `s_axis_tkeep` in 8, `s_axis_tvalid` in 1, `s_axis_tlast` in 1, `s_axis_tuser` in 1: input frame stream from the MAC receive FIFO.
- `s_axis_tready` out 1: input backpressure.
- `m_axis_tdata` out 64, `m_axis_tkeep` out 8, `m_axis_tvalid` out 1, `m_axis_tlast` out 1, `m_axis_tuser` out 1: filtered output stream.
- `m_axis_tready` in 1: output backpressure.
- `local_mac` in 48: station address. `[47:40]` is the first byte on the wire.
- `promisc_en` in 1: pass all frames of at least 6 bytes.
- `bcast_en` in 1: pass destination ff:ff:ff:ff:ff:ff.
- `mcast_en` in 1: pass destinations with the group bit set (bit 0 of first byte).
- `frame_pass` out 1: one-cycle pulse per forwarded frame.
- `frame_drop` out 1: one-cycle pulse per discarded frame.
- `pass_count` out `COUNT_WIDTH`: forwarded frames, wraps.
- `drop_count` out `COUNT_WIDTH`: discarded frames, wraps.

## Operation
- Byte lane 0 (`tdata[7:0]`) is the first wire byte. The destination is `{tdata[7:0], tdata[15:8], ..., tdata[47:40]}` of the first beat.
- States:
  - `IDLE`: next accepted beat is a frame's first beat.
  - `PASS`: forwarding the rest of the frame.
  - `DROP`: discarding the rest of the frame.
- The match decision is evaluated combinationally on the first beat only. Config inputs are sampled at that beat; changing them mid-frame has no effect on the current frame.
- The frame is dropped if `tkeep[5:0] != 6'h3F` on the first beat (runt), regardless of mode.
- Otherwise the frame passes if any of these holds:
  - `promisc_en`;
  - destination == `local_mac`;
  - `bcast_en` and destination is all ones;
  - `mcast_en` and destination bit 40 (group bit) is set and the destination is not broadcast.
- Transitions on an accepted beat (`s_axis_tvalid && s_axis_tready`):
  - `IDLE`, first beat with tlast: stay in `IDLE` (single-beat frame).
  - `IDLE`, first beat without tlast: go to `PASS` or `DROP` per the decision.
  - `PASS` or `DROP`, beat with tlast: go to `IDLE`.
- Passing beats are copied unmodified, including `tuser`, into a one-entry output register.
- Dropped beats are never presented on `m_axis`.
- `s_axis_tready` is:
  - 1 in `DROP`;
  - 1 in `IDLE` when the decision is drop;
  - otherwise `m_axis_tready || !m_axis_tvalid`.
- Counters and pulses are updated once per frame, on the accepted first beat. `pass_count` and `drop_count` wrap from all-ones to 0.

## Timing
- Reset (async assert, synchronous release) forces:
  - state = `IDLE`;
  - `m_axis_tvalid`, `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tlast`, `m_axis_tuser` = 0;
  - `frame_pass`, `frame_drop` = 0;
  - both counters = 0.
- `s_axis_tready` is 1 out of reset, because `IDLE` with an empty output register gives tready = 1.
- Latency: an accepted passing beat appears on `m_axis` the next cycle.
- Throughput: one beat per cycle when `m_axis_tready` is held high.
- Discard rate: one beat per cycle, independent of `m_axis_tready`.
- `frame_pass` and `frame_drop` assert in the cycle after first-beat acceptance, for exactly 1 cycle. The counters show the new value in that same cycle.
- `m_axis_*` stays stable while `m_axis_tvalid && !m_axis_tready`.
- The end of a passed frame and the first beat of the next frame may be accepted on consecutive cycles, with no bubble.
- Reset mid-frame: the output register is cleared and the partial frame is lost. The next input beat is treated as a first beat, so upstream must also be reset.
- Simultaneous output pop and input push of a passing beat in the same cycle must be accepted.

## Test plan
- `local_mac` = 02:00:00:00:00:01; send a 3-beat frame whose first beat has `tdata[47:0]` = 0x010000000002 -> frame on `m_axis` 1 cycle later, bit-identical; `frame_pass` pulses once; `pass_count` = 1.
- Same setup; send a frame to 02:00:00:00:00:99 with `m_axis_tready` = 0 -> `m_axis_tvalid` stays 0; `s_axis_tready` stays 1 on every beat; `drop_count` = 1.
- Broadcast frame with `bcast_en` = 0, then with `bcast_en` = 1 -> first is dropped, second is passed; multicast 01:00:5e:00:00:01 passes only with `mcast_en` = 1.
- Single-beat runt frame with tkeep = 0x0F and tlast, with `promisc_en` = 1 -> dropped; state returns to `IDLE`; the following valid frame passes.
- 1000 back-to-back passing frames with random `m_axis_tready` -> no beat loss or duplication; `pass_count` = 1000; `m_axis_*` stable while stalled.
- Assert `logic_rst_n` low mid-frame with `m_axis_tvalid` = 1 -> all outputs and counters are 0 immediately, without waiting for a clock edge.
